serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller built around one instance of the team's 1-bit full_sub cell (X, Y, Z -> Diff, Borr). A start/done handshake accepts two WIDTH-bit operands and a borrow-in. The controller feeds the cell one bit per clock, LSB first, and recirculates the borrow through a register. It returns the WIDTH-bit difference, borrow-out and zero flag. This gives area-cheap subtraction for the arithmetic datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; latched when start is accepted
b  input  WIDTH  subtrahend; latched when start is accepted
bin  input  1  borrow-in; latched when start is accepted
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow; 1 when a < b + bin (unsigned)
zero  output  1  diff == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, bout=0, zero=0. Operand shift registers, borrow register and counter are cleared.
- Reset mid-operation aborts immediately; the partial result is discarded and no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a->sa, b->sb, bin->br, cnt=0; next state RUN.
- RUN: each edge applies X=sa[0], Y=sb[0], Z=br to the cell.
  - Cell Diff shifts into the result register at the MSB; the result register shifts right.
  - Cell Borr loads br.
  - sa and sb shift right by 1; cnt increments.
  - When cnt==WIDTH-1 at that edge, next state is DONE.
- Cell function: Diff = X^Y^Z; Borr = (~X&Y) | (~X&Z) | (Y&Z).
- RUN lasts exactly WIDTH cycles. Start at edge k gives the last bit at edge k+WIDTH; done=1 in the cycle after edge k+WIDTH.
- At entry to DONE, registered in the same edge as the last bit:
  - diff = full result register
  - bout = final borrow
  - zero = (diff == 0)
- DONE lasts one cycle; done=1 there only.
  - start=0 -> IDLE.
  - start=1 -> accepted exactly as in IDLE (new operands latched), next state RUN. Back-to-back throughput is one result per WIDTH+1 cycles.
- start in RUN is ignored. It is neither queued nor does it disturb operands.
- Latched operands are insensitive to changes on a, b, bin after acceptance.
- diff, bout and zero hold their values from the DONE entry until the next DONE entry. They do not clear on a new start, so they stay stable while busy.
- busy=1 exactly in RUN; busy and done are never both high.
- Wrap-around: result is modulo 2^WIDTH; underflow is reported only through bout.
- Counter saturation does not occur: cnt resets on every accepted start.

Test Plan:
1. Reset, WIDTH=8, a=0x05, b=0x03, bin=0, one-cycle start -> busy high for 8 cycles, then done pulse; diff=0x02, bout=0, zero=0.
2. a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, zero=0. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
3. a=0x80, b=0x80, bin=0 -> diff=0x00, bout=0, zero=1. a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
4. Start a=0x10, b=0x01; in RUN cycle 3 pulse start with a=0xAA, b=0x55 and toggle a/b every cycle -> first-op result diff=0x0F, bout=0. Second start ignored: exactly one done pulse and busy never re-extends.
5. Hold start=1 with new operands (a=0x20, b=0x21) during the DONE cycle of test 1 -> busy re-asserts the next cycle. diff stays 0x02 during RUN, then second done with diff=0xFF, bout=1. Gap between done pulses is 9 cycles.
6. Assert rst_n low asynchronously mid-edge in RUN cycle 4 -> outputs zero immediately, with no done pulse. After release, a fresh op a=0x07, b=0x07 gives diff=0x00, zero=1.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_ctrl (with full_sub cell)
// Brief    : Bit-serial WIDTH-bit subtractor. One full_sub cell, LSB first,
//            with the borrow recirculated through a register.
// Revision : 1.0 - initial release
// ============================================================================

module full_sub (
    input  logic i_x,
    input  logic i_y,
    input  logic i_z,
    output logic o_diff,
    output logic o_borr
);
    assign o_diff = i_x ^ i_y ^ i_z;
    assign o_borr = (~i_x & i_y) | (~i_x & i_z) | (i_y & i_z);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_RUN  = 2'd1;
    localparam logic [1:0]    S_DONE = 2'd2;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_cell_diff;
    logic             w_cell_borr;
    logic [WIDTH-1:0] w_res_nxt;

    full_sub u_cell (
        .i_x    (r_sa[0]),
        .i_y    (r_sb[0]),
        .i_z    (r_br),
        .o_diff (w_cell_diff),
        .o_borr (w_cell_borr)
    );

    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_cnt == c_last);
    assign w_res_nxt = {w_cell_diff, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Results are captured on the final bit edge, so they stay stable while a
    // following operation is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_br  <= w_cell_borr;
            r_res <= w_res_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= w_res_nxt;
                r_bout <= w_cell_borr;
                r_zero <= (w_res_nxt == '0);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign zero = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub_ctrl
// Brief    : Self-checking bench for serial_sub_ctrl: arithmetic reference
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_sub_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an operation occupies W cycles, then results appear
    // for one cycle; the answer itself is plain wide subtraction.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic         m_zero;
    logic [W-1:0] p_diff;
    logic         p_bout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_zero <= 1'b0;
            p_diff <= '0;
            p_bout <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_diff <= p_diff;
                    m_bout <= p_bout;
                    m_zero <= (p_diff == '0);
                end
            end else if (start) begin
                {p_bout, p_diff} <= {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
                m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
            check("cyc_done", {31'b0, done}, {31'b0, m_done});
            check("cyc_diff", {24'b0, diff}, {24'b0, m_diff});
            check("cyc_bout", {31'b0, bout}, {31'b0, m_bout});
            check("cyc_zero", {31'b0, zero}, {31'b0, m_zero});
            check("cyc_excl", {31'b0, busy & done}, 32'd0);
        end
    end

    task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'b0, done}, 32'd1);
    endtask

    task automatic check_res(input string name, input logic [W-1:0] ed, input logic eb, input logic ez);
        check({name, "_diff"}, {24'b0, diff}, {24'b0, ed});
        check({name, "_bout"}, {31'b0, bout}, {31'b0, eb});
        check({name, "_zero"}, {31'b0, zero}, {31'b0, ez});
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic [W-1:0] ed, input logic eb, input logic ez);
        int n;
        do_start(ta, tb, tbin);
        wait_done(name, n);
        check_res(name, ed, eb, ez);
    endtask

    initial begin
        int n;
        int nd;
        int nb_after;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check_res("rst", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic op, latency, then back-to-back start held in DONE
        do_start(8'h05, 8'h03, 1'b0);
        wait_done("t1", n);
        check("t1_latency", n, 32'd8);
        check_res("t1", 8'h02, 1'b0, 1'b0);
        a = 8'h20; b = 8'h21; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_rebusy", {31'b0, busy}, 32'd1);
        check("t5_hold_diff", {24'b0, diff}, 32'h02);
        wait_done("t5", n);
        check("t5_gap", n + 1, 32'd9);
        check_res("t5", 8'hFF, 1'b1, 1'b0);

        run_op("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("t3a", 8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1);
        run_op("t3b", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);

        // Start during RUN is ignored; operands toggle after acceptance
        do_start(8'h10, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        nd = 0;
        nb_after = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = ~a;
            b = ~b;
            if (done) begin
                nd++;
                check_res("t4", 8'h0F, 1'b0, 1'b0);
            end else if (nd > 0 && busy) begin
                nb_after++;
            end
        end
        check("t4_ndone", nd, 32'd1);
        check("t4_rebusy", nb_after, 32'd0);

        // Asynchronous reset in the middle of an operation
        do_start(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_done", {31'b0, done}, 32'd0);
        check_res("t6_rst", 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("t6_quiet", nd, 32'd0);
        run_op("t6b", 8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
